seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
- Receive-side counterpart of the team's hex-to-7-segment decoder.
- Monitors the multiplexed display bus (active-low segments plus active-low digit anodes) and recovers the displayed hex value and decimal point for each digit.
- Used for self-check and readback of the chronometer display, and in benches to compare shown time against counter state.
- Filters scan transitions and glitches with a stability window.

Parameters:
N_DIGITS, 4, number of multiplexed digits / anode lines
IDXW, 2, width of digit index (ceil(log2(N_DIGITS)))
STABLE_CYC, 8, consecutive identical legal samples required before capture (range 2..255)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
seg_in  in  8  display segments, active-low; [7..1]=a,b,c,d,e,f,g, [0]=dp
an_in  in  N_DIGITS  anode enables, active-low; bit i low selects digit i
digit_val  out  4*N_DIGITS  recovered nibble, digit i at [4i+3:4i]
dot_val  out  N_DIGITS  recovered decimal point, 1 = lit
digit_ok  out  N_DIGITS  digit i holds a valid recovered glyph
glyph_err  out  N_DIGITS  last capture of digit i was an unrecognised pattern
upd  out  1  one-cycle pulse: a digit was captured
upd_idx  out  IDXW  index of the digit captured with upd
frame  out  1  one-cycle pulse: every digit captured at least once since the last frame

Behaviour:
- Reset (async, active-high): all outputs 0. State is IDLE, run counter is 0, seen-mask is 0. Both sync stages load all-ones (blank bus) so no capture can occur on release.
- Input sync: seg_in and an_in each pass through 2 flops. All logic below uses the synced values.
- Sample legality: legal iff exactly one an bit is low.
  - All-high (blank) and multi-low samples are illegal.
- Run counter R: counts consecutive cycles with a legal sample identical (seg and an) to the previous cycle's sample.
  - R resets to 1 on any change to a legal sample.
  - R resets to 0 on an illegal sample.
  - R saturates at STABLE_CYC.
- States:
  - IDLE: entered on an illegal sample. Go to SETTLE on a legal sample.
  - SETTLE: when R reaches STABLE_CYC, capture and go to HELD. On a sample change, stay in SETTLE with R=1. On an illegal sample, go to IDLE.
  - HELD: no further capture while the sample is unchanged. On a change, go to SETTLE. On an illegal sample, go to IDLE.
- Capture of digit i is a registered update:
  - dot_val[i] = ~seg[0].
  - Lit pattern L = ~seg[7:1] (order abcdefg). Decoding:
    - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110010
    - 8=1111111, 9=1110011, A=1111101, B=0011111, C=0001101, D=0111101, E=1101111, F=1000111
  - Match: digit_val[i] = nibble, digit_ok[i]=1, glyph_err[i]=0.
  - L=0000000 (blank digit): digit_ok[i]=0, glyph_err[i]=0, digit_val[i] unchanged.
  - Any other L: digit_ok[i]=0, glyph_err[i]=1, digit_val[i] unchanged.
  - upd=1 and upd_idx=i for exactly one cycle per capture.
- Latency: let E0 be the first clock edge that samples a new stable bus value on the pins. Outputs and upd update on edge E0+STABLE_CYC+2.
- Other digits' registers are never touched by a capture.
- frame:
  - The seen-mask ORs in bit i on each capture, blank or error captures included.
  - When a capture makes the mask all-ones: frame=1 in the same cycle as upd, and the mask clears to 0 on that edge.
  - Recapturing an already-seen digit sets no new bit.
- Reset mid-operation: immediate clear of all outputs, counter and mask. A partial dwell never produces a capture after reset release.

Test Plan:
1. Reset, then an_in=1110, seg_in=8'b00001101 (glyph 3, dp off) held 20 cycles -> single upd with upd_idx=0 at edge E0+10; digit_val[3:0]=4'h3; digit_ok[0]=1; dot_val[0]=0; no further upd.
2. an_in=1101, seg_in=8'b00000000 (pattern 8, dp lit) held 7 cycles, then an_in=1111 -> no upd and outputs unchanged. The same stimulus held 8 cycles -> upd, digit_val[7:4]=4'h8, dot_val[1]=1.
3. an_in=1011 with L=1010101 for 12 cycles -> glyph_err[2]=1, digit_ok[2]=0, previous digit_val[11:8] retained. Then glyph A (seg_in=8'b00000101) -> glyph_err[2]=0, digit_val[11:8]=4'hA.
4. an_in=1100 or 1111 with any seg for 30 cycles -> no upd, state stays IDLE, outputs unchanged.
5. Scan digits 0,1,2,3 with glyphs 1,2,5,9, 12 cycles each -> four upd pulses with idx 0..3; frame=1 together with the idx 3 upd; digit_val=16'h9521; a repeat scan yields a second frame.
6. Assert rst for 1 cycle midway through a SETTLE dwell of digit 1 -> all outputs 0 immediately; no upd until a fresh full STABLE_CYC dwell after release.

Source files
------------

// File: rtl/seg_scan_capture.sv
// Recovers per-digit hex values and decimal points from a multiplexed active-low 7-segment bus.
// A bus value must be stable for STABLE_CYC synced samples before it is captured; blank and multi-anode samples are ignored.
module seg_scan_capture #(
   parameter int N_DIGITS   = 4,
   parameter int IDXW       = 2,
   parameter int STABLE_CYC = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            seg_in,
   input  logic [N_DIGITS-1:0]   an_in,
   output logic [4*N_DIGITS-1:0] digit_val,
   output logic [N_DIGITS-1:0]   dot_val,
   output logic [N_DIGITS-1:0]   digit_ok,
   output logic [N_DIGITS-1:0]   glyph_err,
   output logic                  upd,
   output logic [IDXW-1:0]       upd_idx,
   output logic                  frame
);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   localparam logic [7:0] STABLE = 8'(STABLE_CYC);

   state_t                state;
   logic [7:0]            seg_s1, seg_s2, seg_prev, cap_seg;
   logic [N_DIGITS-1:0]   an_s1, an_s2, an_prev, seen, seen_nxt;
   logic [7:0]            run, run_nxt;
   logic                  cap_vld, legal, same, capture;
   logic [IDXW-1:0]       cur_idx, cap_idx;
   logic [4:0]            dec;
   logic [6:0]            lit;

   function automatic logic [4:0] decode(input logic [6:0] l);
      case (l)
         7'b1111110: decode = 5'h10;
         7'b0110000: decode = 5'h11;
         7'b1101101: decode = 5'h12;
         7'b1111001: decode = 5'h13;
         7'b0110011: decode = 5'h14;
         7'b1011011: decode = 5'h15;
         7'b1011111: decode = 5'h16;
         7'b1110010: decode = 5'h17;
         7'b1111111: decode = 5'h18;
         7'b1110011: decode = 5'h19;
         7'b1111101: decode = 5'h1A;
         7'b0011111: decode = 5'h1B;
         7'b0001101: decode = 5'h1C;
         7'b0111101: decode = 5'h1D;
         7'b1101111: decode = 5'h1E;
         7'b1000111: decode = 5'h1F;
         default:    decode = 5'h00;
      endcase
   endfunction

   always_comb begin
      int nlow;
      nlow    = 0;
      cur_idx = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (!an_s2[i]) begin
            nlow    = nlow + 1;
            cur_idx = IDXW'(i);
         end
      end
      legal = (nlow == 1);
      same  = (seg_s2 == seg_prev) && (an_s2 == an_prev);
      if (!legal)
         run_nxt = 8'd0;
      else if (!same)
         run_nxt = 8'd1;
      else if (run == STABLE)
         run_nxt = run;
      else
         run_nxt = run + 8'd1;
      // Capture decision is taken one edge before the outputs move.
      capture  = legal && same && (state == SETTLE) && (run_nxt == STABLE) && (run != STABLE);
      lit      = ~cap_seg[7:1];
      dec      = decode(lit);
      seen_nxt = seen | (N_DIGITS'(1) << cap_idx);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_s1   <= '1;
         seg_s2   <= '1;
         seg_prev <= '1;
         an_s1    <= '1;
         an_s2    <= '1;
         an_prev  <= '1;
         run      <= '0;
         state    <= IDLE;
         cap_vld  <= 1'b0;
         cap_seg  <= '1;
         cap_idx  <= '0;
      end else begin
         seg_s1   <= seg_in;
         seg_s2   <= seg_s1;
         seg_prev <= seg_s2;
         an_s1    <= an_in;
         an_s2    <= an_s1;
         an_prev  <= an_s2;
         run      <= run_nxt;
         cap_vld  <= capture;
         if (capture) begin
            cap_seg <= seg_s2;
            cap_idx <= cur_idx;
         end
         if (!legal)
            state <= IDLE;
         else if (state == IDLE || !same)
            state <= SETTLE;
         else if (capture)
            state <= HELD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_val <= '0;
         dot_val   <= '0;
         digit_ok  <= '0;
         glyph_err <= '0;
         upd       <= 1'b0;
         upd_idx   <= '0;
         frame     <= 1'b0;
         seen      <= '0;
      end else begin
         upd   <= cap_vld;
         frame <= 1'b0;
         if (cap_vld) begin
            upd_idx          <= cap_idx;
            dot_val[cap_idx] <= ~cap_seg[0];
            digit_ok[cap_idx]  <= dec[4];
            glyph_err[cap_idx] <= !dec[4] && (lit != 7'b0);
            if (dec[4])
               digit_val[4*cap_idx +: 4] <= dec[3:0];
            if (&seen_nxt) begin
               frame <= 1'b1;
               seen  <= '0;
            end else begin
               seen  <= seen_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: table of dwell vectors plus scan, latency and reset sequences.
module tb_seg_scan_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  seg_in;
   logic [3:0]  an_in;
   logic [15:0] digit_val;
   logic [3:0]  dot_val, digit_ok, glyph_err;
   logic        upd, frame;
   logic [1:0]  upd_idx;

   int n_checks = 0;
   int n_fail   = 0;
   int frames   = 0;

   seg_scan_capture #(.N_DIGITS(4), .IDXW(2), .STABLE_CYC(8)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
      .digit_val(digit_val), .dot_val(dot_val), .digit_ok(digit_ok),
      .glyph_err(glyph_err), .upd(upd), .upd_idx(upd_idx), .frame(frame)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  an;
      logic [7:0]  seg;
      int          hold;
      int          n_upd;
      logic [15:0] val;
      logic [3:0]  dot;
      logic [3:0]  ok;
      logic [3:0]  err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [15:0] v, input logic [3:0] d,
                             input logic [3:0] o, input logic [3:0] e);
      check({name, ".digit_val"}, 32'(digit_val), 32'(v));
      check({name, ".dot_val"},   32'(dot_val),   32'(d));
      check({name, ".digit_ok"},  32'(digit_ok),  32'(o));
      check({name, ".glyph_err"}, 32'(glyph_err), 32'(e));
   endtask

   // Drive pins at a negedge, then sample one cycle per following negedge.
   task automatic run_cycles(input int n, inout int k, inout int nupd, inout int first, inout int fcnt,
                             inout int fidx3, inout int idxs[$]);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         k++;
         if (frame) begin
            fcnt++;
            frames++;
         end
         if (upd) begin
            nupd++;
            if (first < 0) first = k;
            idxs.push_back(int'(upd_idx));
            if (frame && upd_idx == 2'd3) fidx3++;
         end
      end
   endtask

   vec_t vecs[7];

   initial begin
      int k, nupd, first, fcnt, fidx3;
      int idxs[$];
      logic [7:0] scan_seg[4];
      logic [3:0] scan_an[4];

      vecs[0] = '{4'b1110, 8'b00001101, 20, 1, 16'h0003, 4'b0000, 4'b0001, 4'b0000};
      vecs[1] = '{4'b1101, 8'b00000000,  7, 0, 16'h0003, 4'b0000, 4'b0001, 4'b0000};
      vecs[2] = '{4'b1101, 8'b00000000,  8, 1, 16'h0083, 4'b0010, 4'b0011, 4'b0000};
      vecs[3] = '{4'b1011, 8'b01010101, 12, 1, 16'h0083, 4'b0010, 4'b0011, 4'b0100};
      vecs[4] = '{4'b1011, 8'b00000101, 12, 1, 16'h0A83, 4'b0010, 4'b0111, 4'b0000};
      vecs[5] = '{4'b1100, 8'b00001101, 30, 0, 16'h0A83, 4'b0010, 4'b0111, 4'b0000};
      vecs[6] = '{4'b1111, 8'b10011111, 30, 0, 16'h0A83, 4'b0010, 4'b0111, 4'b0000};
      scan_seg = '{8'b10011111, 8'b00100101, 8'b01001001, 8'b00011001};
      scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

      rst    = 1'b1;
      seg_in = 8'hFF;
      an_in  = 4'hF;
      repeat (3) @(negedge clk);
      check_outs("reset", 16'h0, 4'h0, 4'h0, 4'h0);
      check("reset.upd", 32'(upd), 32'd0);
      check("reset.frame", 32'(frame), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      foreach (vecs[v]) begin
         k = 0; nupd = 0; first = -1; fcnt = 0; fidx3 = 0;
         idxs.delete();
         an_in  = vecs[v].an;
         seg_in = vecs[v].seg;
         run_cycles(vecs[v].hold, k, nupd, first, fcnt, fidx3, idxs);
         an_in  = 4'hF;
         seg_in = 8'hFF;
         run_cycles(14, k, nupd, first, fcnt, fidx3, idxs);
         check($sformatf("vec%0d.n_upd", v), 32'(nupd), 32'(vecs[v].n_upd));
         if (vecs[v].n_upd == 1) begin
            check($sformatf("vec%0d.latency", v), 32'(first), 32'd11);
            if (idxs.size() > 0) begin
               int exp_idx;
               exp_idx = 0;
               for (int i = 0; i < 4; i++) if (!vecs[v].an[i]) exp_idx = i;
               check($sformatf("vec%0d.upd_idx", v), 32'(idxs[0]), 32'(exp_idx));
            end
         end
         check_outs($sformatf("vec%0d", v), vecs[v].val, vecs[v].dot, vecs[v].ok, vecs[v].err);
      end
      check("table.frames", 32'(frames), 32'd0);

      // Two full scans, back to back digits with no blanking between them.
      for (int r = 0; r < 2; r++) begin
         k = 0; nupd = 0; first = -1; fcnt = 0; fidx3 = 0;
         idxs.delete();
         for (int d = 0; d < 4; d++) begin
            an_in  = scan_an[d];
            seg_in = scan_seg[d];
            run_cycles(12, k, nupd, first, fcnt, fidx3, idxs);
         end
         an_in  = 4'hF;
         seg_in = 8'hFF;
         run_cycles(14, k, nupd, first, fcnt, fidx3, idxs);
         check($sformatf("scan%0d.n_upd", r), 32'(nupd), 32'd4);
         for (int i = 0; i < 4; i++)
            if (i < idxs.size())
               check($sformatf("scan%0d.idx%0d", r, i), 32'(idxs[i]), 32'(i));
         check($sformatf("scan%0d.frames", r), 32'(fcnt), 32'd1);
         check($sformatf("scan%0d.frame_with_idx3", r), 32'(fidx3), 32'd1);
         check_outs($sformatf("scan%0d", r), 16'h9521, 4'h0, 4'hF, 4'h0);
      end

      // Reset in the middle of a dwell on digit 1.
      k = 0; nupd = 0; first = -1; fcnt = 0; fidx3 = 0;
      idxs.delete();
      an_in  = 4'b1101;
      seg_in = 8'b00100101;
      run_cycles(5, k, nupd, first, fcnt, fidx3, idxs);
      #2 rst = 1'b1;
      #1;
      check_outs("midrst", 16'h0, 4'h0, 4'h0, 4'h0);
      check("midrst.upd", 32'(upd), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      k = 0; nupd = 0; first = -1;
      idxs.delete();
      run_cycles(10, k, nupd, first, fcnt, fidx3, idxs);
      check("midrst.no_early_upd", 32'(nupd), 32'd0);
      run_cycles(6, k, nupd, first, fcnt, fidx3, idxs);
      check("midrst.n_upd", 32'(nupd), 32'd1);
      check("midrst.latency", 32'(first), 32'd11);
      check_outs("midrst.after", 16'h0020, 4'h0, 4'b0010, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
